mem_access_ctrl: RTL

Parametrised, multi-cycle data-memory access controller for the MEM stage. It accepts one load/store/LL/SC request at a time from EX and drives a valid/ready request channel to the data cache. It waits for read data, then aligns, sign- or zero-extends and writes back the result. It also owns the LL/SC link bit, detects misaligned accesses, handles pipeline flushes mid-transaction, and stalls upstream while busy.

---
 rtl/mem_access_if.sv | 45 ++++
 rtl/mem_access_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_if.sv
// Bundle of the EX request, data-cache request/response and write-back signals
// that surround mem_access_ctrl. Signal suffixes are from the controller's view.
interface mem_access_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [3:0]            req_op_i;
  logic [ADDR_W-1:0]     req_addr_i;
  logic [DATA_W-1:0]     req_wdata_i;
  logic [4:0]            req_wd_i;
  logic                  flush_i;
  logic                  llbit_clear_i;
  logic                  dc_req_valid_o;
  logic                  dc_req_ready_i;
  logic [ADDR_W-1:0]     dc_addr_o;
  logic                  dc_we_o;
  logic [DATA_W/8-1:0]   dc_wstrb_o;
  logic [DATA_W-1:0]     dc_wdata_o;
  logic                  dc_rvalid_i;
  logic [DATA_W-1:0]     dc_rdata_i;
  logic                  wb_valid_o;
  logic [DATA_W-1:0]     wb_data_o;
  logic [4:0]            wb_wd_o;
  logic                  wb_excp_o;
  logic                  stall_o;
  logic                  llbit_o;

  // Environment side: pipeline plus data cache.
  modport master (
    output req_valid_i, req_op_i, req_addr_i, req_wdata_i, req_wd_i,
           flush_i, llbit_clear_i, dc_req_ready_i, dc_rvalid_i, dc_rdata_i,
    input  req_ready_o, dc_req_valid_o, dc_addr_o, dc_we_o, dc_wstrb_o,
           dc_wdata_o, wb_valid_o, wb_data_o, wb_wd_o, wb_excp_o, stall_o, llbit_o
  );

  // Controller side.
  modport slave (
    input  req_valid_i, req_op_i, req_addr_i, req_wdata_i, req_wd_i,
           flush_i, llbit_clear_i, dc_req_ready_i, dc_rvalid_i, dc_rdata_i,
    output req_ready_o, dc_req_valid_o, dc_addr_o, dc_we_o, dc_wstrb_o,
           dc_wdata_o, wb_valid_o, wb_data_o, wb_wd_o, wb_excp_o, stall_o, llbit_o
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: one load/store/LL/SC at a time,
// valid/ready request to the data cache, lane extraction and extension of
// read data, LL/SC link bit, misalignment detection and flush handling.
module mem_access_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  mem_access_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_DONE} state_e;

  state_e state, state_n;

  // Decoded view of the presented request.
  logic [1:0] op_size;
  logic       op_signed, op_load, op_store, op_ll, op_sc, op_illegal;
  logic       misaligned, ale, sc_fail, accept, dc_hs;

  // Fields captured at accept.
  logic [1:0]    r_size;
  logic          r_signed, r_load, r_ll, r_sc;
  logic [LB-1:0] r_lane;

  // Registered outputs.
  logic              llbit_q, dc_req_valid_q, dc_we_q, wb_valid_q, wb_excp_q;
  logic [ADDR_W-1:0] dc_addr_q;
  logic [NB-1:0]     dc_wstrb_q;
  logic [DATA_W-1:0] dc_wdata_q, wb_data_q;
  logic [4:0]        wb_wd_q;

  // Store data replicated across every lane group of the access size.
  function automatic logic [DATA_W-1:0] replicate(input logic [DATA_W-1:0] d,
                                                  input logic [1:0] size);
    logic [DATA_W-1:0] r;
    case (size)
      2'd0:    r = {NB{d[7:0]}};
      2'd1:    r = {(NB/2){d[15:0]}};
      2'd2:    r = {(NB/4){d[31:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Byte-lane enables for an access of the given size starting at lane.
  function automatic logic [NB-1:0] strobe(input logic [LB-1:0] lane,
                                           input logic [1:0] size);
    logic [NB-1:0] m;
    case (size)
      2'd0:    m = NB'(1);
      2'd1:    m = NB'(3);
      2'd2:    m = NB'(15);
      default: m = '1;
    endcase
    return m << lane;
  endfunction

  // Shift the addressed lanes to bit 0, then sign- or zero-extend to DATA_W
  // by pushing the field to the top and shifting back down.
  function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] rd,
                                                input logic [LB-1:0] lane,
                                                input logic [1:0] size,
                                                input logic sgn);
    logic [DATA_W-1:0] s;
    int                sh;
    sh = DATA_W - (8 << size);
    s  = rd >> {lane, 3'b000};
    s  = s << sh;
    if (sgn) s = $signed(s) >>> sh;
    else     s = s >> sh;
    return s;
  endfunction

  assign accept = bus.req_valid_i && (state == S_IDLE);
  assign dc_hs  = dc_req_valid_q && bus.dc_req_ready_i;

  // Decode op code into size, signedness, class, and ALE condition.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    op_size    = 2'd0;
    op_signed  = 1'b0;
    op_load    = 1'b0;
    op_store   = 1'b0;
    op_ll      = 1'b0;
    op_sc      = 1'b0;
    op_illegal = 1'b0;
    misaligned = 1'b0;
    case (bus.req_op_i)
      4'd0, 4'd1, 4'd2, 4'd3: begin
        op_size = bus.req_op_i[1:0]; op_signed = 1'b1; op_load = 1'b1;
      end
      4'd4, 4'd5, 4'd6: begin
        op_size = bus.req_op_i[1:0]; op_load = 1'b1;
      end
      4'd8, 4'd9, 4'd10, 4'd11: begin
        op_size = bus.req_op_i[1:0]; op_store = 1'b1;
      end
      4'd12: begin
        op_size = 2'd2; op_signed = 1'b1; op_load = 1'b1; op_ll = 1'b1;
      end
      4'd13: begin
        op_size = 2'd2; op_store = 1'b1; op_sc = 1'b1;
      end
      default: op_illegal = 1'b1;
    endcase
    // Doubleword ops and WU only exist on a 64-bit data path.
    if (DATA_W == 32 && (op_size == 2'd3 || bus.req_op_i == 4'd6)) op_illegal = 1'b1;
    case (op_size)
      2'd1:    misaligned = bus.req_addr_i[0];
      2'd2:    misaligned = |bus.req_addr_i[1:0];
      2'd3:    misaligned = |bus.req_addr_i[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign ale     = op_illegal || misaligned;
  // A link clear arriving together with the SC already counts as lost link.
  assign sc_fail = op_sc && (!llbit_q || bus.llbit_clear_i);

  // State register.
  // NOTE: sequential blocks use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state decision for the transaction sequence.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (ale || sc_fail) state_n = S_DONE;
          else                state_n = S_REQ;
        end
      end
      S_REQ: begin
        // A load the cache took in the flush cycle still returns data to drop.
        if (bus.flush_i)  state_n = (dc_hs && r_load) ? S_DRAIN : S_IDLE;
        else if (dc_hs)   state_n = r_load ? S_WAIT : S_DONE;
      end
      S_WAIT: begin
        if (bus.flush_i)          state_n = bus.dc_rvalid_i ? S_IDLE : S_DRAIN;
        else if (bus.dc_rvalid_i) state_n = S_DONE;
      end
      S_DRAIN: if (bus.dc_rvalid_i) state_n = S_IDLE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Request capture, cache request register, write-back results and link bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_size         <= 2'd0;
      r_signed       <= 1'b0;
      r_load         <= 1'b0;
      r_ll           <= 1'b0;
      r_sc           <= 1'b0;
      r_lane         <= '0;
      llbit_q        <= 1'b0;
      dc_req_valid_q <= 1'b0;
      dc_we_q        <= 1'b0;
      dc_addr_q      <= '0;
      dc_wstrb_q     <= '0;
      dc_wdata_q     <= '0;
      wb_valid_q     <= 1'b0;
      wb_data_q      <= '0;
      wb_wd_q        <= 5'd0;
      wb_excp_q      <= 1'b0;
    end else begin
      wb_valid_q <= (state_n == S_DONE);
      if (accept) begin
        r_size         <= op_size;
        r_signed       <= op_signed;
        r_load         <= op_load;
        r_ll           <= op_ll;
        r_sc           <= op_sc;
        r_lane         <= bus.req_addr_i[LB-1:0];
        dc_req_valid_q <= !(ale || sc_fail);
        dc_addr_q      <= {bus.req_addr_i[ADDR_W-1:LB], {LB{1'b0}}};
        dc_we_q        <= op_store;
        dc_wstrb_q     <= strobe(bus.req_addr_i[LB-1:0], op_size);
        dc_wdata_q     <= replicate(bus.req_wdata_i, op_size);
        wb_data_q      <= '0;
        wb_wd_q        <= bus.req_wd_i;
        wb_excp_q      <= ale;
      end
      // Request drops only on handshake or flush; address/data stay put.
      if (state == S_REQ && (dc_hs || bus.flush_i)) dc_req_valid_q <= 1'b0;
      if (state == S_REQ && dc_hs && r_sc) wb_data_q <= DATA_W'(1);
      if (state == S_WAIT && bus.dc_rvalid_i && !bus.flush_i)
        wb_data_q <= extract(bus.dc_rdata_i, r_lane, r_size, r_signed);
      if (bus.llbit_clear_i)
        llbit_q <= 1'b0;
      else if (state == S_WAIT && bus.dc_rvalid_i && !bus.flush_i && r_ll)
        llbit_q <= 1'b1;
      else if (state == S_REQ && dc_hs && r_sc)
        llbit_q <= 1'b0;
    end
  end

  assign bus.req_ready_o    = (state == S_IDLE);
  assign bus.stall_o        = (state != S_IDLE);
  assign bus.dc_req_valid_o = dc_req_valid_q;
  assign bus.dc_addr_o      = dc_addr_q;
  assign bus.dc_we_o        = dc_we_q;
  assign bus.dc_wstrb_o     = dc_wstrb_q;
  assign bus.dc_wdata_o     = dc_wdata_q;
  // A flush during the completion cycle cancels the write-back.
  assign bus.wb_valid_o     = wb_valid_q && !bus.flush_i;
  assign bus.wb_data_o      = wb_data_q;
  assign bus.wb_wd_o        = wb_wd_q;
  assign bus.wb_excp_o      = wb_excp_q;
  assign bus.llbit_o        = llbit_q;
endmodule
